tl_phase_sched: RTL and testbench
=================================

Name: tl_phase_sched

Overview:
Timed two-road intersection scheduler with a pedestrian walk phase. It shares the intersection between road A (main, rests green) and road B (side) using sensor inputs Ta/Tb, and enforces minimum/maximum green, yellow and all-red clearance intervals counted in enable ticks. It services latched pedestrian requests with an all-red WALK phase. It drives the La/Lb light codes consumed by the signal-head drivers.

Parameters:
CW, 4, timer width in bits; all durations must be in 1..2^CW
MIN_GRN, 4, minimum green duration in ticks (1 <= MIN_GRN <= MAX_GRN)
MAX_GRN, 15, maximum green duration in ticks when the other road or a pedestrian is waiting
YEL, 2, yellow duration in ticks
ALLRED, 1, all-red clearance duration in ticks
WALK, 5, pedestrian walk duration in ticks

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
tick  in  1  single-cycle timebase enable; timers advance only when tick=1
Ta  in  1  road A traffic present
Tb  in  1  road B traffic present
ped_req  in  1  pedestrian button pulse, any width
La  out  2  road A light: GREEN=00, YELLOW=01, RED=10
Lb  out  2  road B light, same encoding
walk  out  1  pedestrian WALK lamp
ped_ack  out  1  one-cycle pulse on entry to the WALK phase
phase  out  3  current state encoding, for debug

Behaviour:
- One clock; reset is asynchronous and active-low (clk, reset_n). Reset: state=AG, tmr=0, ped_pend=0, next_b=0, La=00, Lb=10, walk=0, ped_ack=0, phase=AG.
- States: AG(0) AY(1) AR1(2) BG(3) BY(4) AR2(5) PW(6). Encoding 7 is illegal and recovers to AG on the next clock.
- Moore outputs. AG: La=G, Lb=R. AY: La=Y, Lb=R. AR1/AR2/PW: both R. BG: La=R, Lb=G. BY: La=R, Lb=Y. walk=1 only in PW. There is no combinational path from any input to La/Lb/walk.
- Timer tmr: cleared on every state change. On tick it increments and saturates at all-ones. "Done(D)" means tick=1 and tmr==D-1. A transition happens at the clock edge of the qualifying tick cycle, so a phase of D ticks with tick held at 1 lasts exactly D cycles.
- ped_pend: set by ped_req=1 in any state except PW. Cleared on the transition into PW. A ped_req during PW, including the entry cycle, is dropped.
- AG -> AY: tick and tmr>=MIN_GRN-1 and (Tb or ped_pend) and (!Ta or tmr==MAX_GRN-1). With no B traffic and no pedestrian, AG rests indefinitely.
- AY -> AR1 on Done(YEL). AR1 on Done(ALLRED): if ped_pend, go to PW with next_b=1; else go to BG.
- BG -> BY: tick and tmr>=MIN_GRN-1 and (!Tb or ped_pend or tmr==MAX_GRN-1).
- BY -> AR2 on Done(YEL). AR2 on Done(ALLRED): if ped_pend, go to PW with next_b=0; else go to AG.
- PW on Done(WALK): go to BG if next_b else AG.
- ped_ack is high for the single cycle where state==PW and the previous state!=PW.
- tick=0 freezes all timers and timed transitions. Sensors and ped_req are still sampled every cycle, and ped_pend still latches.
- Reset asserted mid-phase returns to AG immediately and asynchronously, with ped_pend discarded.

Decomposition:
- Package tl_pkg holds the light codes GREEN/YELLOW/RED and the 3-bit state encodings AG..PW. The existing light controller imports the same light codes.
- Sub-module tl_phase_timer: CW-bit counter with synchronous clear, tick enable, saturation, and a done output from a comparison against a duration input. It is instantiated once, and the FSM muxes in the active duration.

Test Plan:
- Reset release with tick=1, Ta=1, Tb=1 -> AG 15 cycles, AY 2, AR1 1, BG 15, BY 2, AR2 1, back to AG; La/Lb codes match per state.
- tick=1, Ta=0, Tb=1 -> AG lasts exactly 4 cycles, then AY (La=01).
- tick=1, Ta=0, Tb=0, no ped_req, 100 cycles -> remains AG, La=00, Lb=10 throughout.
- tick=1, Ta=0, Tb=0, ped_req pulse at cycle 1 -> AG 4, AY 2, AR1 1, PW 5 (walk=1, ped_ack high only on PW's first cycle), then BG. A second ped_req during PW is dropped: after BG, the path runs BY -> AR2 -> AG with no PW.
- tick once every 4 cycles, Ta=0, Tb=1 -> AG lasts 16 cycles; hold tick=0 for 50 cycles mid-AY -> state and tmr frozen.
- reset_n pulsed low mid-BY -> La=00, Lb=10, walk=0 asynchronously; the pending pedestrian request is cleared.

Source files
------------

// File: rtl/tl_phase_sched_pkg.sv
// Shared light codes and phase encodings for the two-road intersection scheduler.
// The signal-head light controller imports the same light codes.
package tl_pkg;

  localparam logic [1:0] GREEN  = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] RED    = 2'b10;

  localparam logic [2:0] AG  = 3'd0;
  localparam logic [2:0] AY  = 3'd1;
  localparam logic [2:0] AR1 = 3'd2;
  localparam logic [2:0] BG  = 3'd3;
  localparam logic [2:0] BY  = 3'd4;
  localparam logic [2:0] AR2 = 3'd5;
  localparam logic [2:0] PW  = 3'd6;

  typedef struct packed {
    logic [1:0] la;
    logic [1:0] lb;
    logic       walk;
  } lights_t;

  // Illegal encodings show all-red until the FSM recovers on the next clock.
  function automatic lights_t decode_lights(input logic [2:0] st);
    lights_t l;
    l = '{la: RED, lb: RED, walk: 1'b0};
    case (st)
      AG:      l.la = GREEN;
      AY:      l.la = YELLOW;
      BG:      l.lb = GREEN;
      BY:      l.lb = YELLOW;
      PW:      l.walk = 1'b1;
      default: ;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/tl_phase_sched_if.sv
// Sensor/request inputs and light outputs of the phase scheduler, bundled as one bus.
interface tl_phase_sched_if;

  logic       tick;
  logic       Ta;
  logic       Tb;
  logic       ped_req;
  logic [1:0] La;
  logic [1:0] Lb;
  logic       walk;
  logic       ped_ack;
  logic [2:0] phase;

  modport master (
    output tick, Ta, Tb, ped_req,
    input  La, Lb, walk, ped_ack, phase
  );

  modport slave (
    input  tick, Ta, Tb, ped_req,
    output La, Lb, walk, ped_ack, phase
  );

endinterface

// File: rtl/tl_phase_timer.sv
// Tick-enabled saturating phase timer with synchronous clear and a duration-match done flag.
module tl_phase_timer #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr,
  input  logic          tick,
  input  logic [CW-1:0] dur_m1,
  output logic [CW-1:0] tmr,
  output logic          done
);

  logic [CW-1:0] tmr_q, tmr_d;

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    tmr_d = tmr_q;
    if (clr)
      tmr_d = '0;
    else if (tick && (tmr_q != '1))
      tmr_d = tmr_q + CW'(1);
  end

  // NOTE: state flops use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) tmr_q <= '0;
    else          tmr_q <= tmr_d;
  end

  assign tmr  = tmr_q;
  assign done = tick && (tmr_q == dur_m1);

endmodule

// File: rtl/tl_phase_sched.sv
// Two-road intersection phase scheduler with min/max green, yellow, all-red clearance
// and a latched pedestrian all-red WALK phase; all outputs are decoded from flops.
module tl_phase_sched
  import tl_pkg::*;
#(
  parameter int CW      = 4,
  parameter int MIN_GRN = 4,
  parameter int MAX_GRN = 15,
  parameter int YEL     = 2,
  parameter int ALLRED  = 1,
  parameter int WALK    = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  tl_phase_sched_if.slave   bus
);

  localparam logic [CW-1:0] MIN_M1  = CW'(MIN_GRN - 1);
  localparam logic [CW-1:0] MAX_M1  = CW'(MAX_GRN - 1);
  localparam logic [CW-1:0] YEL_M1  = CW'(YEL - 1);
  localparam logic [CW-1:0] AR_M1   = CW'(ALLRED - 1);
  localparam logic [CW-1:0] WALK_M1 = CW'(WALK - 1);

  logic [2:0]    state_q, state_d;
  logic          ped_pend_q, ped_pend_d;
  logic          next_b_q, next_b_d;
  logic          ped_ack_q, ped_ack_d;
  logic [CW-1:0] tmr, dur_m1;
  logic          done, clr, enter_pw, min_ok;
  lights_t       lights;

  tl_phase_timer #(.CW(CW)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clr),
    .tick    (bus.tick),
    .dur_m1  (dur_m1),
    .tmr     (tmr),
    .done    (done)
  );

  assign min_ok = bus.tick && (tmr >= MIN_M1);

  always_comb begin
    state_d  = state_q;
    next_b_d = next_b_q;
    dur_m1   = MAX_M1;
    case (state_q)
      AG: if (min_ok && (bus.Tb || ped_pend_q) && (!bus.Ta || tmr == MAX_M1))
            state_d = AY;
      AY: begin
        dur_m1 = YEL_M1;
        if (done) state_d = AR1;
      end
      AR1: begin
        dur_m1 = AR_M1;
        if (done) begin
          if (ped_pend_q) begin
            state_d  = PW;
            next_b_d = 1'b1;
          end else begin
            state_d = BG;
          end
        end
      end
      BG: if (min_ok && (!bus.Tb || ped_pend_q || tmr == MAX_M1))
            state_d = BY;
      BY: begin
        dur_m1 = YEL_M1;
        if (done) state_d = AR2;
      end
      AR2: begin
        dur_m1 = AR_M1;
        if (done) begin
          if (ped_pend_q) begin
            state_d  = PW;
            next_b_d = 1'b0;
          end else begin
            state_d = AG;
          end
        end
      end
      PW: begin
        dur_m1 = WALK_M1;
        if (done) state_d = next_b_q ? BG : AG;
      end
      default: state_d = AG;
    endcase

    clr       = (state_d != state_q);
    enter_pw  = (state_d == PW) && (state_q != PW);
    ped_ack_d = enter_pw;

    // Requests seen while walking (including the entry cycle) are already being served.
    ped_pend_d = ped_pend_q;
    if (enter_pw)
      ped_pend_d = 1'b0;
    else if (bus.ped_req && (state_q != PW))
      ped_pend_d = 1'b1;
  end

  // NOTE: every control flop gets an async reset value; there is no storage array to leave unreset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= AG;
      ped_pend_q <= 1'b0;
      next_b_q   <= 1'b0;
      ped_ack_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ped_pend_q <= ped_pend_d;
      next_b_q   <= next_b_d;
      ped_ack_q  <= ped_ack_d;
    end
  end

  assign lights      = decode_lights(state_q);
  assign bus.La      = lights.la;
  assign bus.Lb      = lights.lb;
  assign bus.walk    = lights.walk;
  assign bus.ped_ack = ped_ack_q;
  assign bus.phase   = state_q;

endmodule

// File: tb/tb_tl_phase_sched.sv
// Directed self-checking bench for tl_phase_sched: phase durations, resting green,
// pedestrian service, tick gating and asynchronous reset.
module tb_tl_phase_sched;
  import tl_pkg::*;

  logic clk;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;

  tl_phase_sched_if bus ();

  tl_phase_sched dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected light codes written out from the phase table.
  function automatic logic [1:0] exp_la(input logic [2:0] ph);
    case (ph)
      3'd0:    return 2'b00;
      3'd1:    return 2'b01;
      default: return 2'b10;
    endcase
  endfunction

  function automatic logic [1:0] exp_lb(input logic [2:0] ph);
    case (ph)
      3'd3:    return 2'b00;
      3'd4:    return 2'b01;
      default: return 2'b10;
    endcase
  endfunction

  task automatic check_now(input string tag, input logic [2:0] ph, input logic ack);
    check({tag, ".phase"}, 8'(bus.phase), 8'(ph));
    check({tag, ".La"}, 8'(bus.La), 8'(exp_la(ph)));
    check({tag, ".Lb"}, 8'(bus.Lb), 8'(exp_lb(ph)));
    check({tag, ".walk"}, 8'(bus.walk), 8'(ph == 3'd6));
    check({tag, ".ped_ack"}, 8'(bus.ped_ack), 8'(ack));
  endtask

  // Expect phase ph for n consecutive cycles; entry=1 means the run starts on entry to it.
  task automatic expect_run(input string tag, input logic [2:0] ph, input int n, input bit entry);
    for (int i = 0; i < n; i++) begin
      check_now($sformatf("%s[%0d]", tag, i), ph, entry && (ph == 3'd6) && (i == 0));
      step();
    end
  endtask

  // Reset pulse placed between clock edges; reset values are checked while it is held.
  task automatic do_reset();
    step();
    reset_n = 1'b0;
    #2;
    check_now("reset", 3'd0, 1'b0);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n     = 1'b0;
    bus.tick    = 1'b1;
    bus.Ta      = 1'b1;
    bus.Tb      = 1'b1;
    bus.ped_req = 1'b0;

    // Both roads busy: max-green cycling.
    do_reset();
    expect_run("busy_ag", 3'd0, 15, 1);
    expect_run("busy_ay", 3'd1, 2, 1);
    expect_run("busy_ar1", 3'd2, 1, 1);
    expect_run("busy_bg", 3'd3, 15, 1);
    expect_run("busy_by", 3'd4, 2, 1);
    expect_run("busy_ar2", 3'd5, 1, 1);

    // A empty, B waiting: min green; then B empties mid-cycle.
    bus.Ta = 1'b0;
    expect_run("min_ag", 3'd0, 4, 1);
    expect_run("min_ay", 3'd1, 2, 1);
    expect_run("min_ar1", 3'd2, 1, 1);
    bus.Tb = 1'b0;
    expect_run("min_bg", 3'd3, 4, 1);
    expect_run("min_by", 3'd4, 2, 1);
    expect_run("min_ar2", 3'd5, 1, 1);

    // No demand: AG rests.
    expect_run("rest_ag", 3'd0, 100, 1);

    // Pedestrian request serviced, second request during WALK dropped.
    do_reset();
    expect_run("ped_ag0", 3'd0, 1, 1);
    bus.ped_req = 1'b1;
    expect_run("ped_ag1", 3'd0, 1, 1);
    bus.ped_req = 1'b0;
    expect_run("ped_ag2", 3'd0, 2, 1);
    expect_run("ped_ay", 3'd1, 2, 1);
    expect_run("ped_ar1", 3'd2, 1, 1);
    expect_run("ped_pw_a", 3'd6, 2, 1);
    bus.ped_req = 1'b1;
    expect_run("ped_pw_b", 3'd6, 1, 0);
    bus.ped_req = 1'b0;
    expect_run("ped_pw_c", 3'd6, 2, 0);
    expect_run("ped_bg", 3'd3, 4, 1);
    expect_run("ped_by", 3'd4, 2, 1);
    expect_run("ped_ar2", 3'd5, 1, 1);
    expect_run("ped_ag_end", 3'd0, 6, 1);

    // Sparse tick: one tick every 4 cycles stretches AG to 16 cycles.
    bus.Tb   = 1'b1;
    bus.tick = 1'b0;
    do_reset();
    for (int cyc = 0; cyc < 20; cyc++) begin
      bus.tick = ((cyc % 4) == 3);
      check_now($sformatf("sparse[%0d]", cyc), (cyc < 16) ? 3'd0 : 3'd1, 1'b0);
      step();
    end

    // Freeze mid-AY: one more tick completes the yellow only if tmr held its value.
    bus.tick = 1'b0;
    expect_run("frz_ay", 3'd1, 50, 0);
    bus.tick = 1'b1;
    expect_run("frz_ay_end", 3'd1, 1, 0);
    expect_run("frz_ar1", 3'd2, 1, 1);

    // B busy, pending walk ends BG at min green; reset mid-BY discards the request.
    bus.ped_req = 1'b1;
    expect_run("rst_bg0", 3'd3, 1, 1);
    bus.ped_req = 1'b0;
    expect_run("rst_bg1", 3'd3, 3, 0);
    expect_run("rst_by", 3'd4, 1, 1);
    #3;
    reset_n = 1'b0;
    #1;
    check_now("async_rst", 3'd0, 1'b0);
    #2;
    bus.Tb  = 1'b0;
    reset_n = 1'b1;
    expect_run("post_rst_ag", 3'd0, 10, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
